// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer for a small CPU core.
// It latches interrupt edges, page faults and syscalls as pending bits. At an
// instruction boundary it selects the highest-priority eligible source, pulses
// trap_take for one ENTER cycle and records the cause code and handler vector.
// It then holds the core in supervisor mode until reti.
module trap_ctrl #(
   parameter int NIRQ = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NIRQ-1:0] irq,
   input  logic            syscall,
   input  logic            fault,
   input  logic            ie,
   input  logic            instr_done,
   input  logic            reti,
   output logic            bank,
   output logic            trap_take,
   output logic [2:0]      cause,
   output logic [15:0]     vector,
   output logic            double_fault
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_ENTER = 2'd1,
      S_SUPER = 2'd2
   } state_t;

   localparam logic [15:0] VEC_BASE = 16'h0100;

   state_t          r_state;
   state_t          w_next;

   logic [NIRQ-1:0] r_irq_prev;
   logic [NIRQ-1:0] r_irq_pend;
   logic            r_fault_pend;
   logic            r_sys_pend;
   logic [2:0]      r_sel;
   logic [2:0]      r_cause;
   logic [15:0]     r_vector;
   logic            r_dfault;

   logic [NIRQ-1:0] w_irq_rise;
   logic [NIRQ-1:0] w_clr_irq;
   logic            w_clr_fault;
   logic            w_clr_sys;
   logic            w_accept;
   logic            w_elig;
   logic [2:0]      w_sel;
   logic [15:0]     w_vec_sel;
   logic            w_in_enter;

   assign w_irq_rise = irq & ~r_irq_prev;
   assign w_in_enter = (r_state == S_ENTER);
   // Faults and syscalls are only meaningful from user code; in SUPER they
   // are either dropped (syscall) or escalated to double_fault.
   assign w_accept   = (r_state != S_SUPER);
   assign w_vec_sel  = VEC_BASE + {10'd0, r_sel, 3'd0};

   // Priority select over the registered pending bits only, so a pulse that
   // arrives together with instr_done waits for the next boundary.
   always_comb begin
      w_elig = 1'b0;
      w_sel  = 3'd0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (r_irq_pend[i] && ie) begin
            w_elig = 1'b1;
            w_sel  = 3'(i + 2);
         end
      end
      if (r_sys_pend) begin
         w_elig = 1'b1;
         w_sel  = 3'd1;
      end
      if (r_fault_pend) begin
         w_elig = 1'b1;
         w_sel  = 3'd0;
      end
   end

   // Clear strobes for the one pending bit serviced in ENTER.
   always_comb begin
      w_clr_fault = w_in_enter && (r_sel == 3'd0);
      w_clr_sys   = w_in_enter && (r_sel == 3'd1);
      for (int i = 0; i < NIRQ; i++) begin
         w_clr_irq[i] = w_in_enter && (r_sel == 3'(i + 2));
      end
   end

   // State register; reset parks the core in SUPER so boot code runs privileged.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_SUPER;
      else       r_state <= w_next;
   end

   // Next-state logic; reti counts only in SUPER.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RUN:   if (instr_done && w_elig) w_next = S_ENTER;
         S_ENTER: w_next = S_SUPER;
         S_SUPER: if (reti) w_next = S_RUN;
         default: w_next = S_SUPER;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      bank      = 1'b0;
      trap_take = 1'b0;
      case (r_state)
         S_ENTER: trap_take = 1'b1;
         S_SUPER: bank      = 1'b1;
         default: ;
      endcase
   end

   // Freeze the winner when leaving RUN, so ENTER services the source that was
   // eligible at the boundary even if ie or the pending set changes meanwhile.
   always_ff @(posedge clk) begin
      if (reset)
         r_sel <= 3'd0;
      else if ((r_state == S_RUN) && (w_next == S_ENTER))
         r_sel <= w_sel;
   end

   // Pending bits: set wins over clear. irq_prev follows irq during reset, so a
   // line held high across reset produces no edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_prev   <= irq;
         r_irq_pend   <= '0;
         r_fault_pend <= 1'b0;
         r_sys_pend   <= 1'b0;
      end else begin
         r_irq_prev   <= irq;
         r_irq_pend   <= (r_irq_pend & ~w_clr_irq) | w_irq_rise;
         r_fault_pend <= (r_fault_pend & ~w_clr_fault) | (fault & w_accept);
         r_sys_pend   <= (r_sys_pend & ~w_clr_sys) | (syscall & w_accept);
      end
   end

   // Trap record: cause and vector are loaded in ENTER, visible from the first SUPER cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cause  <= 3'd0;
         r_vector <= VEC_BASE;
      end else if (w_in_enter) begin
         r_cause  <= r_sel;
         r_vector <= w_vec_sel;
      end
   end

   // Sticky double fault: a fault raised while already in supervisor mode.
   always_ff @(posedge clk) begin
      if (reset)
         r_dfault <= 1'b0;
      else if ((r_state == S_SUPER) && fault)
         r_dfault <= 1'b1;
   end

   assign cause        = r_cause;
   assign vector       = r_vector;
   assign double_fault = r_dfault;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed table of single-cycle vectors followed by hand-written
// corner sequences. Expected values are hand-derived from the trap behaviour.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  irq = 4'd0;
   logic        syscall = 1'b0;
   logic        fault = 1'b0;
   logic        ie = 1'b0;
   logic        instr_done = 1'b0;
   logic        reti = 1'b0;
   logic        bank;
   logic        trap_take;
   logic [2:0]  cause;
   logic [15:0] vector;
   logic        double_fault;

   int checks = 0;
   int failures = 0;

   trap_ctrl #(.NIRQ(4)) dut (
      .clk(clk), .reset(reset), .irq(irq), .syscall(syscall), .fault(fault),
      .ie(ie), .instr_done(instr_done), .reti(reti), .bank(bank),
      .trap_take(trap_take), .cause(cause), .vector(vector),
      .double_fault(double_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  irq;
      logic        sc, ft, ie, id, rt;
      logic        bank, take;
      logic [2:0]  cause;
      logic [15:0] vec;
      logic        df;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic rst, input logic [3:0] ir, input logic sc, input logic ft,
                      input logic e, input logic id, input logic rt, input logic b,
                      input logic t, input logic [2:0] c, input logic [15:0] v, input logic d);
      vec_t x;
      x.rst = rst; x.irq = ir; x.sc = sc; x.ft = ft; x.ie = e; x.id = id; x.rt = rt;
      x.bank = b; x.take = t; x.cause = c; x.vec = v; x.df = d;
      tv.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then settle past the edge for sampling.
   task automatic cyc(input logic rst, input logic [3:0] ir, input logic sc, input logic ft,
                      input logic e, input logic id, input logic rt);
      reset = rst; irq = ir; syscall = sc; fault = ft; ie = e; instr_done = id; reti = rt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rst irq  sc ft ie id rt | bank take cause vector df
      add(1, 4'h0, 0,0,0,0,0, 1,0,3'd0,16'h0100,0); // reset state
      add(0, 4'h0, 0,0,0,0,0, 1,0,3'd0,16'h0100,0);
      add(0, 4'h0, 0,0,0,0,1, 0,0,3'd0,16'h0100,0); // first reti -> user
      add(0, 4'h4, 0,0,1,0,0, 0,0,3'd0,16'h0100,0); // irq[2] edge
      add(0, 4'h4, 0,0,1,1,0, 0,1,3'd0,16'h0100,0); // boundary -> ENTER
      add(0, 4'h4, 0,0,1,0,0, 1,0,3'd4,16'h0120,0);
      add(0, 4'h4, 0,0,1,0,0, 1,0,3'd4,16'h0120,0);
      add(0, 4'h4, 0,0,1,0,1, 0,0,3'd4,16'h0120,0);
      add(0, 4'h4, 0,0,1,1,0, 0,0,3'd4,16'h0120,0); // irq_pend[2] was cleared
      add(0, 4'h5, 1,1,1,0,0, 0,0,3'd4,16'h0120,0); // fault+syscall+irq[0]
      add(0, 4'h5, 0,0,1,1,0, 0,1,3'd4,16'h0120,0);
      add(0, 4'h5, 0,0,1,0,0, 1,0,3'd0,16'h0100,0);
      add(0, 4'h5, 0,0,1,0,1, 0,0,3'd0,16'h0100,0);
      add(0, 4'h5, 0,0,1,1,0, 0,1,3'd0,16'h0100,0);
      add(0, 4'h5, 0,0,1,0,0, 1,0,3'd1,16'h0108,0);
      add(0, 4'h5, 0,0,1,0,1, 0,0,3'd1,16'h0108,0);
      add(0, 4'h5, 0,0,1,1,0, 0,1,3'd1,16'h0108,0);
      add(0, 4'h5, 0,0,1,0,0, 1,0,3'd2,16'h0110,0);
      add(0, 4'h5, 0,0,1,0,1, 0,0,3'd2,16'h0110,0);
      add(0, 4'h5, 0,0,1,1,0, 0,0,3'd2,16'h0110,0); // nothing left
      add(0, 4'h7, 0,0,0,0,0, 0,0,3'd2,16'h0110,0); // irq[1] edge, ie=0
      for (int k = 0; k < 5; k++)
         add(0, 4'h7, 0,0,0,1,0, 0,0,3'd2,16'h0110,0); // held while ie=0
      add(0, 4'h7, 0,0,1,1,0, 0,1,3'd2,16'h0110,0);
      add(0, 4'h7, 0,0,1,0,0, 1,0,3'd3,16'h0118,0);
      add(0, 4'h7, 0,0,1,0,1, 0,0,3'd3,16'h0118,0);

      for (int i = 0; i < tv.size(); i++) begin
         cyc(tv[i].rst, tv[i].irq, tv[i].sc, tv[i].ft, tv[i].ie, tv[i].id, tv[i].rt);
         chk($sformatf("row%0d bank", i),   16'(bank),         16'(tv[i].bank));
         chk($sformatf("row%0d take", i),   16'(trap_take),    16'(tv[i].take));
         chk($sformatf("row%0d cause", i),  16'(cause),        16'(tv[i].cause));
         chk($sformatf("row%0d vector", i), vector,            tv[i].vec);
         chk($sformatf("row%0d dfault", i), 16'(double_fault), 16'(tv[i].df));
      end

      // Fault arriving with instr_done waits for the next boundary; a fault in
      // ENTER re-sets the bit being cleared.
      cyc(0, 4'h0, 0,1,1,1,0); chk("late_fault no_take", 16'(trap_take), 16'd0);
      cyc(0, 4'h0, 0,0,1,1,0); chk("late_fault take",    16'(trap_take), 16'd1);
      cyc(0, 4'h0, 0,1,1,0,0); chk("enter_fault cause",  16'(cause), 16'd0);
      chk("enter_fault vector", vector, 16'h0100);
      chk("enter_fault no_df",  16'(double_fault), 16'd0);
      cyc(0, 4'h0, 0,0,1,0,1); chk("enter_fault ret bank", 16'(bank), 16'd0);
      cyc(0, 4'h0, 0,0,1,1,0); chk("set_over_clear take",  16'(trap_take), 16'd1);
      cyc(0, 4'h0, 0,0,1,0,0); chk("set_over_clear cause", 16'(cause), 16'd0);
      cyc(0, 4'h0, 0,0,1,0,1);
      cyc(0, 4'h0, 0,0,1,1,0); chk("set_over_clear drained", 16'(trap_take), 16'd0);

      // Reset during ENTER aborts the trap and flushes pending state.
      cyc(0, 4'h0, 0,1,1,0,0);
      cyc(0, 4'h0, 0,0,1,1,0); chk("abort enter take", 16'(trap_take), 16'd1);
      cyc(1, 4'h0, 0,0,1,0,0); chk("abort take",  16'(trap_take), 16'd0);
      chk("abort bank",   16'(bank), 16'd1);
      chk("abort cause",  16'(cause), 16'd0);
      chk("abort vector", vector, 16'h0100);
      cyc(0, 4'h0, 0,0,1,0,1); chk("abort reti bank", 16'(bank), 16'd0);
      cyc(0, 4'h0, 0,0,1,1,0); chk("abort pend flushed", 16'(trap_take), 16'd0);

      // Syscall and fault in SUPER: dropped / double fault, even with reti.
      cyc(1, 4'h0, 0,0,1,0,0);
      cyc(0, 4'h0, 1,0,1,0,0); chk("super sys no_df", 16'(double_fault), 16'd0);
      cyc(0, 4'h0, 0,1,1,0,1); chk("super fault df",  16'(double_fault), 16'd1);
      chk("super fault reti bank", 16'(bank), 16'd0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 4'h0, 0,0,1,1,0);
         chk($sformatf("dropped sys no_take%0d", k), 16'(trap_take), 16'd0);
      end
      chk("df sticky", 16'(double_fault), 16'd1);
      cyc(1, 4'h0, 0,0,1,0,0); chk("df reset", 16'(double_fault), 16'd0);

      // irq[3] held high across reset gives no edge; a later fresh edge traps.
      cyc(1, 4'h8, 0,0,1,0,0);
      cyc(0, 4'h8, 0,0,1,0,1); chk("irq3 hold bank", 16'(bank), 16'd0);
      cyc(0, 4'h8, 0,0,1,1,0); chk("irq3 hold no_take0", 16'(trap_take), 16'd0);
      cyc(0, 4'h0, 0,0,1,1,0); chk("irq3 release no_take", 16'(trap_take), 16'd0);
      cyc(0, 4'h8, 0,0,1,0,0);
      cyc(0, 4'h8, 0,0,1,1,0); chk("irq3 edge take",  16'(trap_take), 16'd1);
      cyc(0, 4'h8, 0,0,1,0,0); chk("irq3 cause",      16'(cause), 16'd5);
      chk("irq3 vector", vector, 16'h0128);
      chk("irq3 bank",   16'(bank), 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
